// File: rtl/spi_6502_pkg.sv
// Shared definitions for the 6502-bus SPI master: register map, status/control
// bit positions, the half-period terminal count and the FSM state type.
package spi_6502_pkg;

  // Register select values (CPU_AB[1:0])
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_SS   = 2'd3;

  // Bit positions inside the CTRL/STAT register
  localparam int ST_BUSY = 7;
  localparam int ST_DONE = 6;
  localparam int CT_IE   = 0;
  localparam int CT_CPOL = 1;
  localparam int CT_CPHA = 2;

  // A byte takes 16 sck half-periods; the counter parks here when idle
  localparam logic [4:0] HP_END = 5'd16;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

endpackage

// File: rtl/spi_clkgen.sv
// SCK timing generator for spi_master_6502. On start it latches the divider and
// then emits one-clk strobes at the end of every (div+1)-clk half-period:
// lead_edge on half-periods 0,2,..14 and trail_edge on 1,3,..15. hp_cnt counts
// completed half-periods and rests at HP_END when no transfer is running.
module spi_clkgen
  import spi_6502_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] div,
  output logic       lead_edge,
  output logic       trail_edge,
  output logic [4:0] hp_cnt
);

  logic [7:0] cnt;
  logic [7:0] div_q;
  logic       edge_now;

  assign edge_now   = (hp_cnt != HP_END) && (cnt == 8'd0);
  assign lead_edge  = edge_now & ~hp_cnt[0];
  assign trail_edge = edge_now &  hp_cnt[0];

  // Divider down-counter and half-period counter
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation matches the synthesised hardware.
    if (!reset) begin
      cnt    <= 8'd0;
      div_q  <= 8'd0;
      hp_cnt <= HP_END;
    end else if (start) begin
      cnt    <= div;
      div_q  <= div;
      hp_cnt <= 5'd0;
    end else if (edge_now) begin
      cnt    <= div_q;
      hp_cnt <= hp_cnt + 5'd1;
    end else if (hp_cnt != HP_END) begin
      cnt    <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_6502.sv
// Byte-wide SPI master on the 6502 bus (DATA, CTRL/STAT, DIV, SS registers).
// A DATA write in IDLE starts a 16-half-period transfer; completion sets DONE,
// which drives the level irq when IE is set. Reading DATA clears DONE, but a
// completion on the same clk wins.
// Build option: define SPI_MODE_EN to make CPOL/CPHA in CTRL live; otherwise the
// block is fixed to mode 0 and CTRL[2:1] read as zero.
module spi_master_6502
  import spi_6502_pkg::*;
#(
  parameter logic [7:0] DIV_RST = 8'd3,
  parameter int         CS_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            we,
  input  logic [1:0]      rs,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic            sck,
  output logic            mosi,
  input  logic            miso,
  output logic [CS_W-1:0] ss_n,
  output logic            irq
);

  state_t          state, state_next;
  logic            wr, rd;
  logic            start, finish;
  logic            lead_edge, trail_edge;
  logic [4:0]      hp_cnt;
  logic [7:0]      div_q;
  logic [7:0]      rx;
  logic [7:0]      sr;
  logic [7:0]      status;
  logic [7:0]      rd_mux;
  logic [CS_W-1:0] ss_q;
  logic            ie, done;
  logic            cpol, cpha;
  logic            cur_cpol, cur_cpha;
  logic            smp;

  assign wr   = cs & we;
  assign rd   = cs & ~we;
  assign ss_n = ~ss_q;
  assign irq  = done & ie;

  spi_clkgen u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .div        (div_q),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .hp_cnt     (hp_cnt)
  );

`ifdef SPI_MODE_EN
  // Live clock polarity/phase bits; sampled by the datapath at transfer start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpol <= 1'b0;
      cpha <= 1'b0;
    end else if (wr && rs == REG_CTRL) begin
      cpol <= din[CT_CPOL];
      cpha <= din[CT_CPHA];
    end
  end
`else
  assign cpol = 1'b0;
  assign cpha = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next state plus start/finish strobes
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (wr && rs == REG_DATA) begin
          start      = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (hp_cnt == HP_END) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Software-visible control registers; writes are accepted even while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie    <= 1'b0;
      div_q <= DIV_RST;
      ss_q  <= '0;
    end else if (wr) begin
      case (rs)
        REG_CTRL: ie    <= din[CT_IE];
        REG_DIV:  div_q <= din;
        REG_SS:   ss_q  <= din[CS_W-1:0];
        default:  ;
      endcase
    end
  end

  // DONE flag: completion has priority over the clearing DATA read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       done <= 1'b0;
    else if (finish)                  done <= 1'b1;
    else if (rd && rs == REG_DATA)    done <= 1'b0;
  end

  // Shifter, sck/mosi generation and RX capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr       <= 8'd0;
      rx       <= 8'd0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      smp      <= 1'b0;
      cur_cpol <= 1'b0;
      cur_cpha <= 1'b0;
    end else if (start) begin
      sr       <= din;
      cur_cpol <= cpol;
      cur_cpha <= cpha;
      sck      <= cpol;
      // With CPHA=1 the first bit appears on the first sck edge instead
      if (!cpha) mosi <= din[7];
    end else if (finish) begin
      rx  <= sr;
      sck <= cur_cpol;
    end else if (state == S_SHIFT) begin
      if (lead_edge || trail_edge) sck <= ~sck;
      if (lead_edge) begin
        if (cur_cpha) mosi <= sr[7];
        else          smp  <= miso;
      end
      if (trail_edge) begin
        if (cur_cpha) begin
          sr <= {sr[6:0], miso};
        end else begin
          sr   <= {sr[6:0], smp};
          mosi <= sr[6];
        end
      end
    end else begin
      sck <= cpol;
    end
  end

  // Status word and read-data mux
  always_comb begin
    status          = 8'd0;
    status[ST_BUSY] = (state == S_SHIFT);
    status[ST_DONE] = done;
    status[CT_CPHA] = cpha;
    status[CT_CPOL] = cpol;
    status[CT_IE]   = ie;
    case (rs)
      REG_DATA: rd_mux = rx;
      REG_CTRL: rd_mux = status;
      REG_DIV:  rd_mux = div_q;
      REG_SS:   rd_mux = 8'(ss_q);
      default:  rd_mux = 8'd0;
    endcase
  end

  // Registered read port: updates only on a CPU read cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  dout <= 8'd0;
    else if (rd) dout <= rd_mux;
  end

endmodule

// File: tb/tb_spi_master_6502.sv
// Self-checking bench for spi_master_6502: reset values, loopback, irq timing,
// table of fixed and random transfers against a behavioural SPI slave, bus
// collisions, abort by reset and (with SPI_MODE_EN) CPOL=1/CPHA=1 operation.
module tb_spi_master_6502;
  import spi_6502_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [1:0] rs = 2'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;
  logic       sck, mosi, miso, irq;
  logic [3:0] ss_n;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural slave: shifts slave_tx out MSB first and records mosi
  logic       loop_en   = 1'b0;
  logic       mode_cpol = 1'b0;
  logic       mode_cpha = 1'b0;
  logic [7:0] slave_tx  = 8'd0;
  logic [7:0] cap       = 8'd0;
  logic [2:0] bit_idx   = 3'd0;
  int         lead_cnt = 0, trail_cnt = 0, sck_edges = 0, lead_period = 0;
  time        last_lead = 0;

  spi_master_6502 dut (
    .clk  (clk),
    .reset(reset),
    .cs   (cs),
    .we   (we),
    .rs   (rs),
    .din  (din),
    .dout (dout),
    .sck  (sck),
    .mosi (mosi),
    .miso (miso),
    .ss_n (ss_n),
    .irq  (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign miso = loop_en ? mosi : slave_tx[3'd7 - bit_idx];

  always @(sck) begin
    sck_edges++;
    if (sck !== mode_cpol) begin
      if (lead_cnt > 0) lead_period = int'($time - last_lead);
      last_lead = $time;
      lead_cnt++;
      if (!mode_cpha) cap = {cap[6:0], mosi};
      else            bit_idx = 3'(lead_cnt - 1);
    end else begin
      trail_cnt++;
      if (!mode_cpha) bit_idx = bit_idx + 3'd1;
      else            cap = {cap[6:0], mosi};
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] div;
    logic [7:0] tx;
    logic [7:0] slv;
    logic       loop;
    logic [7:0] exp_rx;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [7:0] model_rx(input logic lp, input logic [7:0] tx,
                                          input logic [7:0] slv);
    return lp ? tx : slv;
  endfunction

  function automatic int model_cyc(input logic [7:0] div);
    return 16 * (int'(div) + 1) + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; rs = a; din = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; rs = a;
    @(posedge clk);
    #1;
    d  = dout;
    cs = 1'b0;
  endtask

  task automatic prep(input logic [7:0] s);
    slave_tx = s; cap = 8'd0; bit_idx = 3'd0;
    lead_cnt = 0; trail_cnt = 0; sck_edges = 0; lead_period = 0;
  endtask

  // Start a transfer and count clks from the DATA write edge until irq (IE=1)
  task automatic xfer(input logic [7:0] tx, output int n);
    bus_write(REG_DATA, tx);
    n = 0;
    while (!irq && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] last_rx;
    int         n, t0;

    // 1: reset values
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    check("rst sck", sck, 1'b0);
    check("rst mosi", mosi, 1'b0);
    check("rst ss_n", ss_n, 4'hF);
    check("rst irq", irq, 1'b0);
    check("rst dout", dout, 8'h00);
    bus_read(REG_CTRL, rd); check("rst ctrl", rd, 8'h00);
    bus_read(REG_DIV, rd);  check("rst div", rd, 8'h03);
    bus_read(REG_DATA, rd); check("rst data", rd, 8'h00);

    // 2: loopback mode 0, DIV=3, A5
    bus_write(REG_CTRL, 8'h01);
    loop_en = 1'b1;
    prep(8'h00);
    xfer(8'hA5, n);
    check("t2 busy clks", n, 65);
    check("t2 sck pulses", lead_cnt, 8);
    check("t2 sck period", lead_period, 80);
    check("t2 mosi bits", cap, 8'hA5);
    check("t2 sck idle", sck, 1'b0);
    bus_read(REG_DATA, rd); check("t2 rx", rd, 8'hA5);
    bus_read(REG_CTRL, rd); check("t2 done clr", rd, 8'h01);

    // 3: irq timing with DIV=0
    bus_write(REG_DIV, 8'h00);
    prep(8'h00);
    xfer(8'h3C, n);
    check("t3 irq delay", n, 17);
    bus_read(REG_DATA, rd);
    check("t3 rx", rd, 8'h3C);
    check("t3 irq clr", irq, 1'b0);
    last_rx = 8'h3C;

    // Table: fixed boundary rows then random rows
    vecs[0] = '{div: 8'd0, tx: 8'h00, slv: 8'hFF, loop: 1'b0, exp_rx: 8'hFF, exp_cyc: 17};
    vecs[1] = '{div: 8'd2, tx: 8'hFF, slv: 8'h00, loop: 1'b0, exp_rx: 8'h00, exp_cyc: 49};
    vecs[2] = '{div: 8'd5, tx: 8'h81, slv: 8'h7E, loop: 1'b0, exp_rx: 8'h7E, exp_cyc: 97};
    vecs[3] = '{div: 8'd1, tx: 8'h5A, slv: 8'h11, loop: 1'b1, exp_rx: 8'h5A, exp_cyc: 33};
    for (int i = 4; i < 10; i++) begin
      vecs[i].div  = 8'($urandom_range(0, 4));
      vecs[i].tx   = 8'($urandom);
      vecs[i].slv  = 8'($urandom);
      vecs[i].loop = 1'($urandom_range(0, 1));
      vecs[i].exp_rx  = model_rx(vecs[i].loop, vecs[i].tx, vecs[i].slv);
      vecs[i].exp_cyc = model_cyc(vecs[i].div);
    end
    for (int i = 0; i < 10; i++) begin
      bus_write(REG_DIV, vecs[i].div);
      loop_en = vecs[i].loop;
      prep(vecs[i].slv);
      xfer(vecs[i].tx, n);
      check($sformatf("vec%0d clks", i), n, vecs[i].exp_cyc);
      check($sformatf("vec%0d pulses", i), lead_cnt, 8);
      check($sformatf("vec%0d mosi", i), cap, vecs[i].tx);
      bus_read(REG_DATA, rd);
      check($sformatf("vec%0d rx", i), rd, vecs[i].exp_rx);
      bus_read(REG_CTRL, rd);
      check($sformatf("vec%0d stat", i), rd, 8'h01);
      last_rx = vecs[i].exp_rx;
    end

    // 4: collisions
    bus_write(REG_DIV, 8'h03);
    loop_en = 1'b0;
    prep(8'hC3);
    bus_write(REG_DATA, 8'h5A);
    t0 = cyc;
    bus_read(REG_CTRL, rd);   check("t4 busy", rd, 8'h81);
    bus_write(REG_DATA, 8'hFF);
    bus_write(REG_DIV, 8'h01);
    bus_write(REG_SS, 8'h03); check("t4 ss busy", ss_n, 4'hC);
    while (cyc < t0 + 64) begin
      @(posedge clk);
      #1;
    end
    bus_read(REG_DATA, rd);   check("t4 old rx", rd, last_rx);
    bus_read(REG_CTRL, rd);   check("t4 done wins", rd, 8'h41);
    check("t4 mosi kept", cap, 8'h5A);
    bus_read(REG_DATA, rd);   check("t4 rx", rd, 8'hC3);
    bus_read(REG_CTRL, rd);   check("t4 done clr", rd, 8'h01);
    prep(8'h69);
    xfer(8'h24, n);
    check("t4 new div", n, 33);
    check("t4 irq set", irq, 1'b1);

    // 5: abort by reset at sck edge 5
    bus_write(REG_SS, 8'h05);
    bus_read(REG_DIV, rd);
    prep(8'h00);
    bus_write(REG_DATA, 8'hE7);
    n = 0;
    while (sck_edges < 5 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5 edge wait", (sck_edges >= 5), 1'b1);
    reset = 1'b0;
    #1;
    check("t5 sck", sck, 1'b0);
    check("t5 mosi", mosi, 1'b0);
    check("t5 ss_n", ss_n, 4'hF);
    check("t5 irq", irq, 1'b0);
    check("t5 dout", dout, 8'h00);
    @(negedge clk) reset = 1'b1;
    bus_read(REG_CTRL, rd); check("t5 ctrl", rd, 8'h00);
    bus_read(REG_DATA, rd); check("t5 rx", rd, 8'h00);
    bus_read(REG_DIV, rd);  check("t5 div", rd, 8'h03);
    bus_read(REG_SS, rd);   check("t5 ss", rd, 8'h00);

`ifdef SPI_MODE_EN
    // 6: CPOL=1, CPHA=1
    bus_write(REG_CTRL, 8'h07);
    @(posedge clk);
    #1;
    check("t6 sck idle", sck, 1'b1);
    bus_read(REG_CTRL, rd); check("t6 ctrl", rd, 8'h07);
    mode_cpol = 1'b1;
    mode_cpha = 1'b1;
    prep(8'h96);
    xfer(8'h5B, n);
    check("t6 clks", n, 65);
    check("t6 pulses", lead_cnt, 8);
    check("t6 mosi", cap, 8'h5B);
    check("t6 sck end", sck, 1'b1);
    bus_read(REG_DATA, rd); check("t6 rx", rd, 8'h96);
`else
    // Mode bits are ignored in the fixed mode-0 build
    bus_write(REG_CTRL, 8'h07);
    @(posedge clk);
    #1;
    check("t6 sck fixed", sck, 1'b0);
    bus_read(REG_CTRL, rd); check("t6 ctrl", rd, 8'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
